onewire_slot: RTL and testbench

Bit-slot sequencer for the 1-wire master; sits directly downstream of `counter`, whose running-status output `out` is wired to this block's `tick` input as the timebase strobe. It accepts one command at a time (write-0, write-1/read, bus reset) and drives the open-drain enable for the exact tick-timed low interval. It samples the line at the defined point and reports the read bit or presence result with a one-cycle completion pulse.

---
 rtl/onewire_slot.sv | 211 +++++++++++++++++++++
 tb/tb_onewire_slot.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_slot.sv
// -----------------------------------------------------------------------------
// onewire_slot
//
// Bit-slot sequencer for the 1-wire master. Accepts one command at a time and
// drives the open-drain pull-down enable for a tick-timed low interval, then
// samples the line at a fixed tick offset and reports the result with a
// one-cycle completion pulse.
//
// Commands (cmd, latched only when a request is accepted):
//   2'b00  write-0       : line low for LOW0 ticks of a SLOT-tick slot
//   2'b01  write-1/read  : line low for LOW1 ticks, line sampled at SAMPLE
//   2'b10  bus reset     : line low for RST_LOW ticks, presence sampled at
//                          RST_PRS, slot ends at RST_SLOT
//   2'b11  reserved      : no line activity, done pulses on the next cycle
//
// Handshake: a command is taken on any clk edge where req=1 and ready=1.
// ready is 0 for the whole of a BIT/RST slot and returns to 1 in the same
// cycle that done pulses, so a req held in the done cycle is accepted
// back-to-back. A req while ready=0 is ignored without side effects.
//
// Timebase: tick is a single-cycle strobe from the upstream counter. The slot
// counter advances once per tick while a slot runs; a tick on the acceptance
// edge itself does not count.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous reset, active-high, has priority over req
//   tick   in   timebase strobe
//   req    in   command request
//   cmd    in   [1:0] command, see table above
//   ovd    in   overdrive: every cycle counts as a tick (only when
//               ONEWIRE_OVERDRIVE_EN is defined)
//   ready  out  idle, may accept req
//   done   out  one-cycle completion pulse
//   rdata  out  last sampled line bit (write/read slot)
//   pres   out  last presence result, 1 = device answered
//   owr_e  out  pull line low when 1
//   owr_i  in   line level
//
// Configuration macro: ONEWIRE_OVERDRIVE_EN adds the ovd input. ovd is
// captured at acceptance and held for the whole slot.
//
// All outputs are registered; nothing reaches an output combinationally from
// owr_i, req or tick.
// -----------------------------------------------------------------------------
module onewire_slot #(
    parameter int CW       = 7,
    parameter int SLOT     = 8,
    parameter int LOW0     = 6,
    parameter int LOW1     = 1,
    parameter int SAMPLE   = 2,
    parameter int RST_LOW  = 48,
    parameter int RST_PRS  = 56,
    parameter int RST_SLOT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req,
    input  logic [1:0] cmd,
`ifdef ONEWIRE_OVERDRIVE_EN
    input  logic       ovd,
`endif
    output logic       ready,
    output logic       done,
    output logic       rdata,
    output logic       pres,
    output logic       owr_e,
    input  logic       owr_i
);

    // Slot thresholds at counter width.
    localparam logic [CW-1:0] SLOT_C     = CW'(SLOT);
    localparam logic [CW-1:0] LOW0_C     = CW'(LOW0);
    localparam logic [CW-1:0] LOW1_C     = CW'(LOW1);
    localparam logic [CW-1:0] SAMPLE_C   = CW'(SAMPLE);
    localparam logic [CW-1:0] RST_LOW_C  = CW'(RST_LOW);
    localparam logic [CW-1:0] RST_PRS_C  = CW'(RST_PRS);
    localparam logic [CW-1:0] RST_SLOT_C = CW'(RST_SLOT);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_RST  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] s;          // ticks elapsed since acceptance
    logic          wr1;        // latched: 1 = write-1/read, 0 = write-0
    logic [CW-1:0] s_inc;      // value s takes on an advancing edge
    logic [CW-1:0] low_end;    // count at which the pull-down is released
    logic [CW-1:0] slot_end;   // count at which the slot completes
    logic          adv;        // this edge advances the slot counter

`ifdef ONEWIRE_OVERDRIVE_EN
    logic ovd_q;               // overdrive mode captured for the running slot
    assign adv = tick | ovd_q;
`else
    assign adv = tick;
`endif

    // Per-command thresholds, selected from the latched command.
    always_comb begin
        low_end  = LOW0_C;
        slot_end = SLOT_C;
        if (state == ST_RST) begin
            low_end  = RST_LOW_C;
            slot_end = RST_SLOT_C;
        end else if (wr1) begin
            low_end  = LOW1_C;
        end
    end

    // Saturating increment: the counter holds at its terminal value instead
    // of wrapping. In practice the slot ends on that same edge, so the hold
    // only matters if the FSM were ever to linger in a busy state.
    always_comb begin
        s_inc = s;
        if (s != slot_end) begin
            s_inc = s + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            s     <= '0;
            wr1   <= 1'b0;
            owr_e <= 1'b0;
            done  <= 1'b0;
            rdata <= 1'b0;
            pres  <= 1'b0;
            ready <= 1'b1;
`ifdef ONEWIRE_OVERDRIVE_EN
            ovd_q <= 1'b0;
`endif
        end else begin
            // done is a pulse: only the completing edge (or a no-op accept)
            // raises it, every other edge clears it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // ready is always 1 here, so req alone means acceptance.
                    // The tick on this edge is deliberately not counted.
                    if (req) begin
                        s <= '0;
`ifdef ONEWIRE_OVERDRIVE_EN
                        ovd_q <= ovd;
`endif
                        case (cmd)
                            2'b00, 2'b01: begin
                                state <= ST_BIT;
                                wr1   <= cmd[0];
                                owr_e <= 1'b1;
                                ready <= 1'b0;
                            end
                            2'b10: begin
                                state <= ST_RST;
                                owr_e <= 1'b1;
                                ready <= 1'b0;
                            end
                            default: begin
                                // Reserved command: acknowledge without
                                // touching the line or leaving IDLE.
                                done <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_BIT, ST_RST: begin
                    if (adv) begin
                        s <= s_inc;

                        if (s_inc == low_end) begin
                            owr_e <= 1'b0;
                        end

                        // Read sample happens for write-0 as well; the line
                        // is still held low then, so it reads back 0.
                        if ((state == ST_BIT) && (s_inc == SAMPLE_C)) begin
                            rdata <= owr_i;
                        end

                        // A device answers the reset by holding the line low.
                        if ((state == ST_RST) && (s_inc == RST_PRS_C)) begin
                            pres <= ~owr_i;
                        end

                        if (s_inc == slot_end) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    // Unused encoding: fall back to a clean idle.
                    state <= ST_IDLE;
                    s     <= '0;
                    owr_e <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_slot.sv
// -----------------------------------------------------------------------------
// tb_onewire_slot
//
// Directed and randomized stimulus for onewire_slot. The reference model
// counts ticks since acceptance and derives the line enable, sample points and
// completion edge from the slot thresholds. The line is modelled as open-drain
// (released line reads 1, the master or a device can pull it low) or forced.
// -----------------------------------------------------------------------------
module tb_onewire_slot;

    localparam int CW       = 7;
    localparam int SLOT     = 8;
    localparam int LOW0     = 6;
    localparam int LOW1     = 1;
    localparam int SAMPLE   = 2;
    localparam int RST_LOW  = 48;
    localparam int RST_PRS  = 56;
    localparam int RST_SLOT = 96;

    // line modes
    localparam int LINE_OD = 0;   // open-drain, optional device pull window
    localparam int LINE_HI = 1;   // forced 1
    localparam int LINE_LO = 2;   // forced 0

    // ------------------------------------------------------------------ clock/reset
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       req;
    logic [1:0] cmd;
    logic       owr_i;
    logic       ready, done, rdata, pres, owr_e;
`ifdef ONEWIRE_OVERDRIVE_EN
    logic       ovd;
    localparam bit HAS_OVD = 1'b1;
`else
    localparam bit HAS_OVD = 1'b0;
`endif

    always #5 clk = ~clk;

    onewire_slot #(
        .CW(CW), .SLOT(SLOT), .LOW0(LOW0), .LOW1(LOW1), .SAMPLE(SAMPLE),
        .RST_LOW(RST_LOW), .RST_PRS(RST_PRS), .RST_SLOT(RST_SLOT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .req   (req),
        .cmd   (cmd),
`ifdef ONEWIRE_OVERDRIVE_EN
        .ovd   (ovd),
`endif
        .ready (ready),
        .done  (done),
        .rdata (rdata),
        .pres  (pres),
        .owr_e (owr_e),
        .owr_i (owr_i)
    );

    // ------------------------------------------------------------------ scoreboard
    int          vectors     = 0;
    int          miscompares = 0;
    int          gedge       = 0;     // posedges seen so far
    logic        exp_rdata   = 1'b0;
    logic        exp_pres    = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pops the next expected value from the scoreboard queue.
    task automatic chk_q(input string tag, input int obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=%0d expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk_int(tag, obs, int'(e));
        end
    endtask

    // ------------------------------------------------------------------ drivers
    task automatic cycle();
        @(posedge clk);
        gedge++;
        #1;
    endtask

    function automatic logic tick_at(input int e, input int per, input int ph);
        if (per == 0) return 1'b0;
        if (per == 1) return 1'b1;
        return ((e % per) == ph);
    endfunction

    function automatic logic line(input int mode, input logic pull);
        if (mode == LINE_HI) return 1'b1;
        if (mode == LINE_LO) return 1'b0;
        return ~(owr_e | pull);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req   = 1'b0;
            tick  = 1'($urandom_range(0, 1));
            owr_i = 1'b1;
            cycle();
            chk("idle_done", done, 1'b0);
            chk("idle_ready", ready, 1'b1);
            chk("idle_owr_e", owr_e, 1'b0);
            chk("idle_rdata", rdata, exp_rdata);
            chk("idle_pres", pres, exp_pres);
        end
    endtask

    // Issues one command and follows it to completion (or budget expiry),
    // checking every cycle against the tick-count model.
    //   per/ph : tick every per-th edge at phase ph (per 0 = no ticks)
    //   plo/phi: device pulls the line while the tick count is in [plo,phi]
    //   ov     : overdrive requested at acceptance
    //   junk   : throw random requests at the busy block
    task automatic run_txn(input logic [1:0] c, input int per, input int ph,
                           input int mode, input int plo, input int phi,
                           input logic ov, input int budget, input bit junk,
                           output int low_cyc, output int end_j,
                           output bit completed);
        int   tc, low, slot;
        logic tk, ow, pull, inc, fin, ov_eff;
        low_cyc   = 0;
        end_j     = -1;
        completed = 1'b0;
        ov_eff    = HAS_OVD ? ov : 1'b0;
        low  = (c == 2'b10) ? RST_LOW  : (c == 2'b01) ? LOW1 : LOW0;
        slot = (c == 2'b10) ? RST_SLOT : SLOT;

        req   = 1'b1;
        cmd   = c;
        tick  = tick_at(gedge + 1, per, ph);
        owr_i = line(mode, 1'b0);
`ifdef ONEWIRE_OVERDRIVE_EN
        ovd = ov;
`endif
        cycle();
        req = 1'b0;
        cmd = 2'($urandom_range(0, 3));   // must not matter once latched
`ifdef ONEWIRE_OVERDRIVE_EN
        ovd = 1'($urandom_range(0, 1));   // must not matter once latched
`endif

        if (c == 2'b11) begin
            chk("nop_done", done, 1'b1);
            chk("nop_ready", ready, 1'b1);
            chk("nop_owr_e", owr_e, 1'b0);
            chk("nop_rdata", rdata, exp_rdata);
            end_j     = 0;
            completed = 1'b1;
            return;
        end

        chk("acc_owr_e", owr_e, 1'b1);
        chk("acc_ready", ready, 1'b0);
        chk("acc_done", done, 1'b0);
        low_cyc = 1;
        tc      = 0;

        for (int j = 1; j <= budget; j++) begin
            pull  = (tc >= plo) && (tc <= phi);
            tk    = tick_at(gedge + 1, per, ph);
            tick  = tk;
            owr_i = line(mode, pull);
            ow    = owr_i;
            if (junk && ($urandom_range(0, 3) == 0)) begin
                req = 1'b1;
                cmd = 2'($urandom_range(0, 3));
            end else begin
                req = 1'b0;
            end
            cycle();

            inc = (tk | ov_eff) && (tc < slot);
            if (inc) tc++;
            if (inc && (c != 2'b10) && (tc == SAMPLE))  exp_rdata = ow;
            if (inc && (c == 2'b10) && (tc == RST_PRS)) exp_pres  = ~ow;
            fin = inc && (tc == slot);

            chk("slot_owr_e", owr_e, (tc < low));
            chk("slot_done", done, fin);
            chk("slot_ready", ready, fin);
            chk("slot_rdata", rdata, exp_rdata);
            chk("slot_pres", pres, exp_pres);
            if (tc < low) low_cyc++;
            if (fin) begin
                end_j     = j;
                completed = 1'b1;
                break;
            end
        end
        req = 1'b0;
    endtask

    // ------------------------------------------------------------------ sequence
    initial begin
        int low_c, end_j, ph;
        bit comp;

        rst   = 1'b1;
        req   = 1'b0;
        cmd   = 2'b00;
        tick  = 1'b0;
        owr_i = 1'b1;
`ifdef ONEWIRE_OVERDRIVE_EN
        ovd = 1'b0;
`endif
        repeat (3) cycle();
        chk("rst_owr_e", owr_e, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_rdata", rdata, 1'b0);
        chk("rst_pres", pres, 1'b0);
        rst = 1'b0;
        idle(2);

        // write-0, tick every cycle, open-drain line
        run_txn(2'b00, 1, 0, LINE_OD, 999, 0, 1'b0, 40, 1'b0, low_c, end_j, comp);
        exp_q.push_back(LOW0);
        exp_q.push_back(SLOT);
        chk_q("w0_low_cycles", low_c);
        chk_q("w0_end_edge", end_j);
        chk("w0_rdata", rdata, 1'b0);
        idle(2);

        // write-1/read, line forced 1 then forced 0
        run_txn(2'b01, 1, 0, LINE_HI, 999, 0, 1'b0, 40, 1'b0, low_c, end_j, comp);
        exp_q.push_back(LOW1);
        exp_q.push_back(SLOT);
        chk_q("w1_low_cycles", low_c);
        chk_q("w1_end_edge", end_j);
        chk("w1_rdata_hi", rdata, 1'b1);
        idle(1);
        run_txn(2'b01, 1, 0, LINE_LO, 999, 0, 1'b0, 40, 1'b0, low_c, end_j, comp);
        chk("w1_rdata_lo", rdata, 1'b0);
        idle(1);

        // bus reset, device pulls during ticks 50..60, then no device
        run_txn(2'b10, 1, 0, LINE_OD, 50, 60, 1'b0, 200, 1'b0, low_c, end_j, comp);
        exp_q.push_back(RST_LOW);
        exp_q.push_back(RST_SLOT);
        chk_q("rst_low_cycles", low_c);
        chk_q("rst_end_edge", end_j);
        chk("pres_device", pres, 1'b1);
        idle(1);
        run_txn(2'b10, 1, 0, LINE_OD, 999, 0, 1'b0, 200, 1'b0, low_c, end_j, comp);
        chk("pres_none", pres, 1'b0);
        idle(1);

        // sparse tick (every 4th edge) aligned so one lands on the acceptance
        // edge and is ignored; busy requests thrown in; then back-to-back
        ph = (gedge + 1) % 4;
        run_txn(2'b00, 4, ph, LINE_OD, 999, 0, 1'b0, 80, 1'b1, low_c, end_j, comp);
        exp_q.push_back(LOW0 * 4);
        exp_q.push_back(SLOT * 4);
        chk_q("sparse_low_cycles", low_c);
        chk_q("sparse_end_edge", end_j);
        run_txn(2'b01, 4, ph, LINE_HI, 999, 0, 1'b0, 80, 1'b0, low_c, end_j, comp);
        chk_int("b2b_complete", int'(comp), 1);
        chk("b2b_rdata", rdata, 1'b1);
        idle(1);

        // reset asserted mid bus-reset slot at s=3, req held alongside
        req   = 1'b1;
        cmd   = 2'b10;
        tick  = 1'b1;
        owr_i = line(LINE_OD, 1'b0);
        cycle();
        req = 1'b0;
        repeat (3) begin
            owr_i = line(LINE_OD, 1'b0);
            cycle();
        end
        chk("mid_owr_e_before", owr_e, 1'b1);
        rst = 1'b1;
        req = 1'b1;
        cmd = 2'b00;
        cycle();
        exp_rdata = 1'b0;
        exp_pres  = 1'b0;
        chk("mid_rst_owr_e", owr_e, 1'b0);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_pres", pres, 1'b0);
        rst = 1'b0;
        req = 1'b0;
        cycle();
        chk("rst_prio_owr_e", owr_e, 1'b0);
        chk("rst_prio_ready", ready, 1'b1);
        run_txn(2'b01, 1, 0, LINE_OD, 999, 0, 1'b0, 40, 1'b0, low_c, end_j, comp);
        chk_int("post_rst_end_edge", end_j, SLOT);
        chk("post_rst_rdata", rdata, 1'b1);
        idle(1);

        // no tick, no overdrive: slot must stall with the line held low
        run_txn(2'b00, 0, 0, LINE_OD, 999, 0, 1'b0, 40, 1'b0, low_c, end_j, comp);
        chk_int("stall_no_complete", int'(comp), 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_rdata = 1'b0;
        exp_pres  = 1'b0;
        chk("stall_recover_ready", ready, 1'b1);

`ifdef ONEWIRE_OVERDRIVE_EN
        // overdrive with no ticks: every cycle counts
        run_txn(2'b00, 0, 0, LINE_OD, 999, 0, 1'b1, 40, 1'b0, low_c, end_j, comp);
        chk_int("ovd_end_edge", end_j, SLOT);
        chk_int("ovd_low_cycles", low_c, LOW0);
        idle(1);
`endif

        // randomized commands, tick densities and line behaviour
        for (int k = 0; k < 24; k++) begin
            logic [1:0] rc;
            int         per, rph, mode, plo;
            rc   = 2'($urandom_range(0, 3));
            per  = $urandom_range(1, 4);
            rph  = $urandom_range(0, per - 1);
            mode = $urandom_range(0, 2);
            plo  = $urandom_range(40, 70);
            run_txn(rc, per, rph, mode, plo, plo + $urandom_range(0, 12),
                    1'($urandom_range(0, 1)), RST_SLOT * 4 + 10,
                    1'($urandom_range(0, 1)), low_c, end_j, comp);
            chk_int("rand_complete", int'(comp), 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
